// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_frame_ctrl
//  Purpose  : Frame sequencer for the rate-1/2 Viterbi decoder. It feeds symbol
//             pairs to BMC/ACS, writes the survivors, then runs the traceback.
//  Revision : 1.0 - initial release
// ============================================================================
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair,
  output logic [1:0]        bmc_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tb_en,
  output logic              tb_start,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_zero = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_DRAIN  = 3'd2,
    S_TRACE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;

  logic [1:0]          r_bmc_pair;
  logic                r_acs_en;
  logic                r_acs_init;
  logic                r_mem_wr_en;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_tb_en;
  logic                r_tb_start;
  logic                r_busy;
  logic                r_frame_done;

  logic [1:0]          w_bmc_pair;
  logic                w_acs_en;
  logic                w_acs_init;
  logic                w_mem_wr_en;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_tb_en;
  logic                w_tb_start;
  logic                w_busy;
  logic                w_frame_done;

  // Every output except in_ready is the registered image of the next-state
  // decode, so strobes line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= c_zero;
      r_bmc_pair   <= 2'b00;
      r_acs_en     <= 1'b0;
      r_acs_init   <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_mem_addr   <= c_zero;
      r_tb_en      <= 1'b0;
      r_tb_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bmc_pair   <= w_bmc_pair;
      r_acs_en     <= w_acs_en;
      r_acs_init   <= w_acs_init;
      r_mem_wr_en  <= w_mem_wr_en;
      r_mem_addr   <= w_mem_addr;
      r_tb_en      <= w_tb_en;
      r_tb_start   <= w_tb_start;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bmc_pair   = r_bmc_pair;
    w_mem_addr   = r_mem_addr;
    w_acs_en     = 1'b0;
    w_acs_init   = 1'b0;
    w_mem_wr_en  = 1'b0;
    w_tb_en      = 1'b0;
    w_tb_start   = 1'b0;
    w_frame_done = 1'b0;

    // Abort outranks start and any accept presented in the same cycle.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = c_zero;
      w_mem_addr  = c_zero;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_ACCEPT;
            w_cnt_nxt   = c_zero;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            w_bmc_pair  = rx_pair;
            w_acs_en    = 1'b1;
            w_mem_wr_en = 1'b1;
            w_acs_init  = (r_cnt == c_zero);
            w_mem_addr  = r_cnt;
            if (r_cnt == c_last) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_cnt_nxt = r_cnt + c_one;
            end
          end
        end
        S_DRAIN: begin
          w_state_nxt = S_TRACE;
          w_cnt_nxt   = c_last;
          w_tb_en     = 1'b1;
          w_tb_start  = 1'b1;
          w_mem_addr  = c_last;
        end
        S_TRACE: begin
          // r_cnt mirrors the address currently being traced back.
          if (r_cnt == c_zero) begin
            w_state_nxt  = S_DONE;
            w_frame_done = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt - c_one;
            w_tb_en    = 1'b1;
            w_mem_addr = r_cnt - c_one;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = c_zero;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = c_zero;
          w_mem_addr  = c_zero;
        end
      endcase
    end

    w_busy = (w_state_nxt != S_IDLE);
  end

  assign in_ready   = (r_state == S_ACCEPT);
  assign bmc_pair   = r_bmc_pair;
  assign acs_en     = r_acs_en;
  assign acs_init   = r_acs_init;
  assign mem_wr_en  = r_mem_wr_en;
  assign mem_addr   = r_mem_addr;
  assign tb_en      = r_tb_en;
  assign tb_start   = r_tb_start;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_frame_ctrl
//  Purpose  : Scoreboard bench for viterbi_frame_ctrl with directed frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_frame_ctrl;

  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        rx_pair;
  logic [1:0]        bmc_pair;
  logic              acs_en;
  logic              acs_init;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              tb_en;
  logic              tb_start;
  logic              busy;
  logic              frame_done;

  viterbi_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_pair    (rx_pair),
    .bmc_pair   (bmc_pair),
    .acs_en     (acs_en),
    .acs_init   (acs_init),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .tb_en      (tb_en),
    .tb_start   (tb_start),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic            wr;
    logic            init;
    logic [1:0]      pair;
    logic [ADDR_W-1:0] addr;
    logic            tb;
    logic            tbs;
    logic            done;
  } ev_t;

  ev_t sb[$];
  int  n_total = 0;
  int  n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (acs_en || mem_wr_en || acs_init || tb_en || tb_start || frame_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe",
            {55'd0, acs_en, mem_wr_en, acs_init, tb_en, tb_start, frame_done, mem_addr[2:0]}, 64'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("event",
            {19'd0, cyc, acs_en, mem_wr_en, acs_init, (acs_en ? bmc_pair : 2'b00),
             mem_addr, tb_en, tb_start, frame_done, busy},
            {19'd0, e.cyc, e.wr, e.wr, e.init, e.pair, e.addr, e.tb, e.tbs, e.done, 1'b1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic wr, input logic init, input logic [1:0] pair,
                         input int addr, input logic tb, input logic tbs, input logic done);
    ev_t e;
    e.cyc = c; e.wr = wr; e.init = init; e.pair = pair;
    e.addr = ADDR_W'(addr); e.tb = tb; e.tbs = tbs; e.done = done;
    sb.push_back(e);
  endtask

  task automatic outs_zero(input string name);
    chk(name, {48'd0, in_ready, bmc_pair, acs_en, acs_init, mem_wr_en, mem_addr,
               tb_en, tb_start, busy, frame_done, 3'd0}, 64'd0);
  endtask

  // One frame; abort_at<FRAME_LEN aborts on that symbol, rst_at>=0 drops rst_n
  // while the traceback address equals rst_at.
  task automatic run_frame(input bit bubble, input int abort_at, input bit start_in_trace,
                           input int rst_at);
    int k = 0;
    int t = 0;
    bit v = 1'b1;
    int n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (k < FRAME_LEN) begin
      logic [1:0] p;
      p = bubble ? 2'(3 - (k % 4)) : 2'(k % 4);
      in_valid = v;
      rx_pair  = p;
      if (v && k == abort_at) begin
        abort = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("abort_idle_addr", {60'd0, mem_addr}, 64'd0);
        return;
      end
      if (v) begin
        push_ev(cyc + 1, 1'b1, (k == 0), p, k, 1'b0, 1'b0, 1'b0);
        if (k == FRAME_LEN - 1) t = cyc;
        k++;
      end
      if (bubble) v = ~v;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (rst_at < 0 || (FRAME_LEN - 1 - i) >= rst_at)
        push_ev(t + 2 + i, 1'b0, 1'b0, 2'b00, FRAME_LEN - 1 - i, 1'b1, (i == 0), 1'b0);
    end
    if (rst_at >= 0) begin
      while (cyc < t + 2 + (FRAME_LEN - 1 - rst_at) && n < 40) begin step(); n++; end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      outs_zero("async_reset_mid_trace");
      @(negedge clk);
      @(negedge clk);
      #1;
      outs_zero("held_reset");
      rst_n = 1'b1;
      step();
      return;
    end
    push_ev(t + FRAME_LEN + 2, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b1);
    while (sb.size() > 0 && n < 60) begin
      if (start_in_trace && cyc == t + 5) start = 1'b1;
      else start = 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    if (n >= 60) chk("frame_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    rx_pair  = 2'b00;
    #3;
    outs_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // IDLE ignores in_valid.
    in_valid = 1'b1;
    rx_pair  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    chk("idle_busy", {63'd0, busy}, 64'd0);

    run_frame(1'b0, FRAME_LEN, 1'b1, -1);   // back-to-back, start pulsed in trace
    run_frame(1'b0, FRAME_LEN, 1'b0, -1);   // started the cycle after frame_done
    step();
    run_frame(1'b1, FRAME_LEN, 1'b0, -1);   // bubbled input
    step();
    run_frame(1'b0, 7, 1'b0, -1);           // abort on symbol 7
    for (int i = 0; i < 4; i++) step();
    run_frame(1'b0, FRAME_LEN, 1'b0, -1);   // restart after abort
    step();
    run_frame(1'b0, FRAME_LEN, 1'b0, 9);    // async reset at trace addr 9
    for (int i = 0; i < 6; i++) step();
    chk("post_reset_idle", {62'd0, busy, in_ready}, 64'd0);
    run_frame(1'b0, FRAME_LEN, 1'b0, -1);
    for (int i = 0; i < 4; i++) step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame-level sequencer for the rate-1/2 Viterbi decoder.
- Accepts received symbol pairs over a valid/ready handshake and presents each pair to the branch-metric (BMC) bank.
- Strobes the add-compare-select (ACS) stage and the survivor path-memory writes once per symbol.
- After FRAME_LEN symbols, runs the traceback pass over the path memory from the last address down to 0, then signals frame completion.

Parameters:
- FRAME_LEN, 16, symbols per frame; legal range 2 to 2**ADDR_W.
- ADDR_W, 4, width of the path-memory address and symbol counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a frame; sampled in IDLE only.
- abort  input  1  synchronous abort; sampled in any state.
- in_valid  input  1  rx_pair is valid.
- in_ready  output  1  controller accepts rx_pair this cycle.
- rx_pair  input  2  received hard-decision symbol pair.
- bmc_pair  output  2  registered symbol pair driven to the BMC bank.
- acs_en  output  1  ACS update strobe, one cycle per symbol.
- acs_init  output  1  with acs_en on symbol 0 only; ACS loads initial path metrics.
- mem_wr_en  output  1  survivor write strobe; coincident with acs_en.
- mem_addr  output  ADDR_W  path-memory address, used for both writes and traceback reads.
- tb_en  output  1  traceback read/step strobe.
- tb_start  output  1  first traceback cycle only.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse when traceback completes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0 immediately: bmc_pair=2'b00, mem_addr=0, and every strobe, in_ready and busy low.
  - State is IDLE and the counter is 0.
- States: IDLE, ACCEPT, DRAIN, TRACE, DONE. All outputs except in_ready are registered.
- IDLE:
  - in_ready=0 and busy=0.
  - start=1 -> ACCEPT with counter k=0.
  - in_valid is ignored.
- ACCEPT:
  - in_ready=1, driven combinationally from state.
  - Accept occurs when in_valid & in_ready at cycle t with counter k.
  - At t+1: bmc_pair=rx_pair, acs_en=1, mem_wr_en=1, mem_addr=k, acs_init=(k==0). Strobes are single-cycle.
  - Cycles without an accept produce no strobes; gaps are allowed and addresses stay contiguous.
  - If k=FRAME_LEN-1, the next state is DRAIN and in_ready=0 from t+1. Otherwise k increments.
- DRAIN:
  - One cycle; carries the final symbol's acs_en/mem_wr_en.
  - Next state is TRACE with k=FRAME_LEN-1.
- TRACE:
  - Lasts FRAME_LEN cycles with tb_en=1.
  - mem_addr runs FRAME_LEN-1 down to 0, decrementing by 1 per cycle.
  - tb_start=1 in the first cycle only.
  - After the address-0 cycle, go to DONE.
- DONE:
  - One cycle: frame_done=1, busy=1.
  - Next state IDLE with busy=0.
  - start in DONE is ignored.
- busy: 1 from the cycle after start through DONE inclusive.
- Latency, for a back-to-back frame with the last accept at cycle t:
  - DRAIN at t+1.
  - TRACE at t+2 .. t+FRAME_LEN+1.
  - frame_done at t+FRAME_LEN+2.
- abort=1 in any non-IDLE state:
  - Next cycle the state is IDLE with all strobes, busy and frame_done at 0. Counter cleared, mem_addr=0.
  - No frame_done is issued for the aborted frame.
  - abort has priority over start and over an accept in the same cycle.
- start while busy is ignored.
- Counter and mem_addr never exceed FRAME_LEN-1. No wrap occurs within a frame.
- Reset asserted mid-frame (any state): outputs are 0 asynchronously. On release the block sits in IDLE awaiting start.

Test Plan:
- Back-to-back frame: reset, start, 16 consecutive valid symbols 00,01,10,11,... ->
  - acs_en/mem_wr_en for 16 consecutive cycles with mem_addr 0..15 and acs_init only at addr 0.
  - bmc_pair matches input delayed by 1 cycle.
  - TRACE: tb_en for 16 cycles, mem_addr 15..0, tb_start on the first cycle.
  - frame_done exactly 18 cycles after the last accept... more precisely, frame_done at t+18 where t is the last-accept cycle.
- Bubbled input: in_valid alternating 1/0 ->
  - Exactly 16 acs_en pulses, addresses 0..15 contiguous.
  - No strobe in cycles following a non-accepted cycle.
- Abort: assert abort on the cycle accepting symbol 7 ->
  - Next cycle: IDLE, busy=0, no acs_en for symbol 7, no frame_done ever.
  - A new start then writes addr 0 with acs_init=1.
- Ignored controls: in_valid=1 in IDLE -> in_ready=0 and no strobes. start pulsed during TRACE -> traceback unaffected and a single frame_done.
- Async reset mid-TRACE: drop rst_n at traceback addr 9 -> tb_en, mem_addr, busy all 0 without waiting for a clock edge. After release, no activity until start.
- Sequential frames: start asserted the cycle after frame_done -> second frame is identical in timing to the first.
